// File: rtl/bra_rs.sv
// Branch reservation station: age-ordered compacting queue that captures CDB
// results and issues the oldest fully-ready branch to BRA each cycle.
module bra_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         disp_valid,
    input  logic [3:0]                   disp_op,
    input  logic [31:0]                  disp_Vj,
    input  logic [31:0]                  disp_Vk,
    input  logic [TAG_W-1:0]             disp_Qj,
    input  logic [TAG_W-1:0]             disp_Qk,
    input  logic                         disp_Rj,
    input  logic                         disp_Rk,
    input  logic [31:0]                  disp_PC,
    input  logic [31:0]                  disp_Offset,
    input  logic [TAG_W-1:0]             disp_Dest,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [31:0]                  cdb_value,
    output logic [3:0]                   BRAOp,
    output logic [31:0]                  BRASrcA,
    output logic [31:0]                  BRASrcB,
    output logic [31:0]                  PC,
    output logic [31:0]                  Offset,
    output logic [TAG_W-1:0]             Dest_in
);

    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic             valid;
        logic [3:0]       op;
        logic [31:0]      vj;
        logic             rj;
        logic [TAG_W-1:0] qj;
        logic [31:0]      vk;
        logic             rk;
        logic [TAG_W-1:0] qk;
        logic [31:0]      pc;
        logic [31:0]      off;
        logic [TAG_W-1:0] dest;
    } entry_t;

    typedef struct packed {
        logic [3:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [31:0]      pc;
        logic [31:0]      off;
        logic [TAG_W-1:0] dest;
    } issue_t;

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    entry_t             ext_c [DEPTH+1];
    entry_t             new_c;
    issue_t             iss_q, iss_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   wr_pos_c;
    logic [DEPTH-1:0]   shift_c;
    logic               issue_c;
    logic               do_disp_c;

    function automatic entry_t wake(input entry_t e, input logic v,
                                    input logic [TAG_W-1:0] tag, input logic [31:0] val);
        entry_t r;
        r = e;
        if (v && e.valid && !e.rj && e.qj == tag) begin
            r.vj = val;
            r.rj = 1'b1;
        end
        if (v && e.valid && !e.rk && e.qk == tag) begin
            r.vk = val;
            r.rk = 1'b1;
        end
        return r;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign BRAOp   = iss_q.op;
    assign BRASrcA = iss_q.a;
    assign BRASrcB = iss_q.b;
    assign PC      = iss_q.pc;
    assign Offset  = iss_q.off;
    assign Dest_in = iss_q.dest;

    always_comb begin
        issue_c = 1'b0;
        iss_d   = '0;
        shift_c = '0;
        // shift_c[i] marks the selected slot and every slot above it
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!issue_c && ent_q[i].valid && ent_q[i].rj && ent_q[i].rk) begin
                issue_c = 1'b1;
                iss_d   = '{op: ent_q[i].op, a: ent_q[i].vj, b: ent_q[i].vk,
                            pc: ent_q[i].pc, off: ent_q[i].off, dest: ent_q[i].dest};
            end
            shift_c[i] = issue_c;
        end

        do_disp_c = disp_valid && !full;
        wr_pos_c  = count_q - CNT_W'(issue_c);
        new_c     = wake('{valid: 1'b1, op: disp_op, vj: disp_Vj, rj: disp_Rj, qj: disp_Qj,
                           vk: disp_Vk, rk: disp_Rk, qk: disp_Qk, pc: disp_PC,
                           off: disp_Offset, dest: disp_Dest},
                         cdb_valid, cdb_tag, cdb_value);

        for (int unsigned i = 0; i < DEPTH; i++) ext_c[i] = ent_q[i];
        ext_c[DEPTH] = '0;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_d[i] = wake(shift_c[i] ? ext_c[i+1] : ext_c[i], cdb_valid, cdb_tag, cdb_value);
            if (do_disp_c && wr_pos_c == CNT_W'(i)) ent_d[i] = new_c;
        end

        count_d = count_q + CNT_W'(do_disp_c) - CNT_W'(issue_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            iss_q   <= '0;
            count_q <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            iss_q   <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            iss_q   <= iss_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_bra_rs.sv
// Scoreboard bench for bra_rs: expected issues are queued at stimulus time and
// matched against every cycle where BRAOp is non-zero.
module tb_bra_rs;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam logic [3:0] BEQ = 4'd1;
    localparam logic [3:0] BNE = 4'd2;

    logic             clk, rst, flush;
    logic             disp_valid;
    logic [3:0]       disp_op;
    logic [31:0]      disp_Vj, disp_Vk, disp_PC, disp_Offset;
    logic [TAG_W-1:0] disp_Qj, disp_Qk, disp_Dest;
    logic             disp_Rj, disp_Rk;
    logic             full;
    logic [2:0]       count;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic [3:0]       BRAOp;
    logic [31:0]      BRASrcA, BRASrcB, PC, Offset;
    logic [TAG_W-1:0] Dest_in;

    typedef struct {
        logic [3:0]       op;
        logic [31:0]      a, b, pc, off;
        logic [TAG_W-1:0] dest;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    bra_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_op(disp_op),
        .disp_Vj(disp_Vj), .disp_Vk(disp_Vk), .disp_Qj(disp_Qj), .disp_Qk(disp_Qk),
        .disp_Rj(disp_Rj), .disp_Rk(disp_Rk), .disp_PC(disp_PC), .disp_Offset(disp_Offset),
        .disp_Dest(disp_Dest), .full(full), .count(count),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .BRAOp(BRAOp), .BRASrcA(BRASrcA), .BRASrcB(BRASrcB), .PC(PC), .Offset(Offset),
        .Dest_in(Dest_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every issue pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (!rst && BRAOp !== 4'd0) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_issue: got op=%0d dest=%0d want no issue", BRAOp, Dest_in);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (BRAOp !== e.op || BRASrcA !== e.a || BRASrcB !== e.b ||
                    PC !== e.pc || Offset !== e.off || Dest_in !== e.dest) begin
                    bad++;
                    $display("FAIL issue_fields: got op=%0d a=%h b=%h pc=%h off=%h dest=%0d want op=%0d a=%h b=%h pc=%h off=%h dest=%0d",
                             BRAOp, BRASrcA, BRASrcB, PC, Offset, Dest_in,
                             e.op, e.a, e.b, e.pc, e.off, e.dest);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] vj, input logic rj,
                         input logic [TAG_W-1:0] qj, input logic [31:0] vk, input logic rk,
                         input logic [TAG_W-1:0] qk, input logic [31:0] pc,
                         input logic [31:0] off, input logic [TAG_W-1:0] dest);
        disp_valid = 1'b1; disp_op = op;
        disp_Vj = vj; disp_Rj = rj; disp_Qj = qj;
        disp_Vk = vk; disp_Rk = rk; disp_Qk = qk;
        disp_PC = pc; disp_Offset = off; disp_Dest = dest;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] tag, input logic [31:0] val);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
    endtask

    task automatic expect_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] pc, input logic [31:0] off,
                                input logic [TAG_W-1:0] dest);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.pc = pc; e.off = off; e.dest = dest;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        tick(); tick();
        rst = 1'b0;
        tick();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full: got %0d want 0", full); end
        total++; if (BRAOp !== 4'd0) begin bad++; $display("FAIL rst_op: got %0d want 0", BRAOp); end
        drive(BEQ, 0, 0, 4'd1, 0, 1, 0, 32'h10, 0, 4'd1); tick();
        drive(BEQ, 0, 0, 4'd1, 0, 1, 0, 32'h20, 0, 4'd2); tick();
        drive(BNE, 3, 1, 0, 3, 1, 0, 32'h30, 32'h4, 4'd3);
        expect_issue(BNE, 3, 3, 32'h30, 32'h4, 4'd3);
        tick();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL fill3_count: got %0d want 3", count); end
        idle(); tick();
        total++; if (BRAOp !== BNE) begin bad++; $display("FAIL pre_rst_op: got %0d want %0d", BRAOp, BNE); end
        #2 rst = 1'b1;
        #1;
        total++; if (BRAOp !== 4'd0 || BRASrcA !== 32'd0 || Dest_in !== '0) begin
            bad++; $display("FAIL async_rst_out: got op=%0d a=%h dest=%0d want 0", BRAOp, BRASrcA, Dest_in); end
        total++; if (count !== 3'd0 || full !== 1'b0) begin
            bad++; $display("FAIL async_rst_cnt: got count=%0d full=%0d want 0/0", count, full); end
        tick();
        rst = 1'b0;
        tick();
        total++; if (BRAOp !== 4'd0 || count !== 3'd0) begin
            bad++; $display("FAIL post_rst: got op=%0d count=%0d want 0/0", BRAOp, count); end
    endtask

    task automatic test_ready();
        drive(BEQ, 5, 1, 0, 5, 1, 0, 32'h100, 32'h20, 4'd2);
        expect_issue(BEQ, 5, 5, 32'h100, 32'h20, 4'd2);
        tick();
        total++; if (count !== 3'd1 || BRAOp !== 4'd0) begin
            bad++; $display("FAIL ready_e1: got count=%0d op=%0d want 1/0", count, BRAOp); end
        idle(); tick();
        total++; if (BRAOp !== BEQ || count !== 3'd0) begin
            bad++; $display("FAIL ready_e2: got op=%0d count=%0d want %0d/0", BRAOp, count, BEQ); end
        tick();
        total++; if (BRAOp !== 4'd0) begin bad++; $display("FAIL ready_e3: got %0d want 0", BRAOp); end
    endtask

    task automatic test_wakeup();
        drive(BNE, 0, 0, 4'd3, 9, 1, 0, 32'h200, 32'h8, 4'd5); tick();
        drive(BEQ, 1, 1, 0, 1, 1, 0, 32'h300, 32'h4, 4'd6);
        expect_issue(BEQ, 1, 1, 32'h300, 32'h4, 4'd6);
        tick();
        total++; if (count !== 3'd2) begin bad++; $display("FAIL wake_count: got %0d want 2", count); end
        idle(); tick();
        total++; if (BRAOp !== BEQ || Dest_in !== 4'd6 || count !== 3'd1) begin
            bad++; $display("FAIL wake_b_first: got op=%0d dest=%0d count=%0d want %0d/6/1", BRAOp, Dest_in, count, BEQ); end
        cdb(4'd3, 32'd7);
        expect_issue(BNE, 7, 9, 32'h200, 32'h8, 4'd5);
        tick();
        total++; if (BRAOp !== 4'd0) begin bad++; $display("FAIL wake_no_fwd: got %0d want 0", BRAOp); end
        idle(); tick();
        total++; if (BRAOp !== BNE || BRASrcA !== 32'd7) begin
            bad++; $display("FAIL wake_a: got op=%0d a=%h want %0d/7", BRAOp, BRASrcA, BNE); end
    endtask

    task automatic test_bypass();
        drive(BEQ, 32'h11, 1, 0, 0, 0, 4'd4, 32'h400, 32'h10, 4'd7);
        cdb(4'd4, 32'hDEAD);
        expect_issue(BEQ, 32'h11, 32'hDEAD, 32'h400, 32'h10, 4'd7);
        tick();
        total++; if (count !== 3'd1) begin bad++; $display("FAIL bypass_count: got %0d want 1", count); end
        idle(); tick();
        total++; if (BRAOp !== BEQ || BRASrcB !== 32'hDEAD) begin
            bad++; $display("FAIL bypass_issue: got op=%0d b=%h want %0d/dead", BRAOp, BRASrcB, BEQ); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive((i % 2 == 0) ? BEQ : BNE, 0, 0, (i < 3) ? TAG_W'(8 + i) : 4'd10,
                  32'h50 + i, 1, 0, 32'h1000 + 32'(i), 32'h40, TAG_W'(8 + i));
            tick();
        end
        total++; if (full !== 1'b1 || count !== 3'd4) begin
            bad++; $display("FAIL full_set: got full=%0d count=%0d want 1/4", full, count); end
        drive(BEQ, 1, 1, 0, 1, 1, 0, 32'h2000, 0, 4'd12); tick();
        total++; if (count !== 3'd4 || BRAOp !== 4'd0) begin
            bad++; $display("FAIL full_reject: got count=%0d op=%0d want 4/0", count, BRAOp); end
        idle(); tick();
        total++; if (BRAOp !== 4'd0) begin bad++; $display("FAIL full_not_stored: got %0d want 0", BRAOp); end
        cdb(4'd9, 32'h99);
        expect_issue(BNE, 32'h99, 32'h51, 32'h1001, 32'h40, 4'd9);
        tick();
        idle(); tick();
        total++; if (Dest_in !== 4'd9 || count !== 3'd3 || full !== 1'b0) begin
            bad++; $display("FAIL full_slot1: got dest=%0d count=%0d full=%0d want 9/3/0", Dest_in, count, full); end
        cdb(4'd8, 32'h88);
        expect_issue(BEQ, 32'h88, 32'h50, 32'h1000, 32'h40, 4'd8);
        tick();
        idle();
        drive(BEQ, 32'h77, 1, 0, 32'h77, 1, 0, 32'h3000, 32'h8, 4'd13);
        expect_issue(BEQ, 32'h77, 32'h77, 32'h3000, 32'h8, 4'd13);
        tick();
        total++; if (count !== 3'd3 || Dest_in !== 4'd8) begin
            bad++; $display("FAIL disp_and_issue: got count=%0d dest=%0d want 3/8", count, Dest_in); end
        idle(); cdb(4'd10, 32'hA0);
        expect_issue(BEQ, 32'hA0, 32'h52, 32'h1002, 32'h40, 4'd10);
        expect_issue(BNE, 32'hA0, 32'h53, 32'h1003, 32'h40, 4'd11);
        tick();
        total++; if (Dest_in !== 4'd13 || count !== 3'd2) begin
            bad++; $display("FAIL new_issue: got dest=%0d count=%0d want 13/2", Dest_in, count); end
        idle(); tick();
        total++; if (Dest_in !== 4'd10) begin bad++; $display("FAIL age_order0: got %0d want 10", Dest_in); end
        tick();
        total++; if (Dest_in !== 4'd11 || count !== 3'd0) begin
            bad++; $display("FAIL age_order1: got dest=%0d count=%0d want 11/0", Dest_in, count); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive(BNE, 32'(i), 1, 0, 32'(i + 1), 1, 0, 32'h500 + 32'(i), 32'hC, TAG_W'(i + 1));
            expect_issue(BNE, 32'(i), 32'(i + 1), 32'h500 + 32'(i), 32'hC, TAG_W'(i + 1));
            tick();
            total++; if (count !== 3'd1) begin bad++; $display("FAIL b2b_count%0d: got %0d want 1", i, count); end
        end
        idle(); tick();
        total++; if (Dest_in !== 4'd3 || count !== 3'd0) begin
            bad++; $display("FAIL b2b_last: got dest=%0d count=%0d want 3/0", Dest_in, count); end
    endtask

    task automatic test_flush();
        drive(BEQ, 0, 0, 4'd12, 0, 1, 0, 32'h600, 0, 4'd1); tick();
        drive(BEQ, 0, 0, 4'd13, 0, 1, 0, 32'h604, 0, 4'd2); tick();
        drive(BNE, 4, 1, 0, 5, 1, 0, 32'h608, 0, 4'd3); tick();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_pre: got %0d want 3", count); end
        drive(BEQ, 1, 1, 0, 1, 1, 0, 32'h60C, 0, 4'd4);
        flush = 1'b1;
        tick();
        total++; if (count !== 3'd0 || BRAOp !== 4'd0) begin
            bad++; $display("FAIL flush_edge: got count=%0d op=%0d want 0/0", count, BRAOp); end
        idle(); cdb(4'd12, 32'h1); tick();
        cdb(4'd13, 32'h2); tick();
        idle(); tick();
        total++; if (count !== 3'd0 || BRAOp !== 4'd0) begin
            bad++; $display("FAIL flush_after: got count=%0d op=%0d want 0/0", count, BRAOp); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        disp_valid = 1'b0; disp_op = '0; disp_Vj = '0; disp_Vk = '0;
        disp_Qj = '0; disp_Qk = '0; disp_Rj = 1'b0; disp_Rk = 1'b0;
        disp_PC = '0; disp_Offset = '0; disp_Dest = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        test_reset();
        test_ready();
        test_wakeup();
        test_bypass();
        test_full();
        test_back_to_back();
        test_flush();
        tick();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL pending_issues: got %0d outstanding want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
